// File: rtl/mas_scheduler.sv
// mas_scheduler
// Shares one modular add/subtract (MAS) datapath between two requesters.
// Requests are arbitrated, pushed through two registered MAS stages
// (S1: raw add/sub, S2: compare against Q and apply the +/-Q correction),
// then held in an output register until the consumer takes them.
// The block also owns the runtime modulus Q and reloads it safely
// (stops granting, drains the pipeline, then writes Q).
//
// Latency: accepted at edge N -> S1 at N, S2 at N+1, response at N+2.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-port request handshake (index 0 = port 0)
//   req_din1/req_din2     per-port signed 5-bit operands, packed {p1,p0}
//   req_op                per-port opcode (0 = add, 1 = subtract)
//   req_tag               per-port tag, packed
//   rsp_valid/rsp_ready   response handshake
//   rsp_port, rsp_tag     originating port and echoed tag
//   rsp_tdout             uncorrected S1 result
//   rsp_tcmp              {TDout >= Q, ~TDout[4]}
//   rsp_dout              corrected result, low 4 bits
//   cfg_q_req, cfg_q      modulus reload request (level) and new value
//   cfg_q_ack, cfg_q_err  reload done pulse; err = value outside 1..8
//   q_cur                 current modulus
//
// Build option: define MAS_SCHED_FIXED_PRIO_EN for fixed priority
// (port 0 always wins, no pointer state); default is round-robin.

module mas_scheduler #(
    parameter logic signed [4:0] Q_RESET = 5'sd7,
    parameter int                TAG_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [9:0]         req_din1,
    input  logic [9:0]         req_din2,
    input  logic [1:0]         req_op,
    input  logic [2*TAG_W-1:0] req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_port,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [4:0]         rsp_tdout,
    output logic [1:0]         rsp_tcmp,
    output logic [3:0]         rsp_dout,
    input  logic               cfg_q_req,
    input  logic [4:0]         cfg_q,
    output logic               cfg_q_ack,
    output logic               cfg_q_err,
    output logic [4:0]         q_cur
);

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD} state_t;

    state_t             state_reg, state_next;
    logic [4:0]         q_reg;
    logic               q_load;
    logic               cfg_hold;
    logic               stall;
    logic [1:0]         grant;
    logic               sel;
    logic               accept;
    logic               prefer1;

    logic               s1_valid_reg, s1_port_reg;
    logic [TAG_W-1:0]   s1_tag_reg;
    logic [4:0]         s1_tdout_reg;

    logic               s2_valid_reg, s2_port_reg;
    logic [TAG_W-1:0]   s2_tag_reg;
    logic [4:0]         s2_tdout_reg;
    logic [1:0]         s2_tcmp_reg;
    logic [3:0]         s2_dout_reg;

    logic [1:0]         tcmp_next;
    logic [4:0]         corr_next;
    logic               q_ok;

    // Per-port unpacking and raw S1 result for each port
    logic [4:0]         raw_arr [2];
    logic [TAG_W-1:0]   tag_arr [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [4:0] d1, d2;
        assign d1          = req_din1[gi*5 +: 5];
        assign d2          = req_din2[gi*5 +: 5];
        assign tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
        assign raw_arr[gi] = req_op[gi] ? (d1 - d2) : (d1 + d2);
    end

    // ---------------- Arbitration ----------------
`ifdef MAS_SCHED_FIXED_PRIO_EN
    assign prefer1 = 1'b0;
`else
    logic ptr_reg;
    // Pointer moves away from whichever port was actually accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr_reg <= 1'b0;
        else if (accept) ptr_reg <= ~sel;
    end
    assign prefer1 = ptr_reg;
`endif

    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11)
            grant = prefer1 ? 2'b10 : 2'b01;
    end

    assign stall     = rsp_valid & ~rsp_ready;
    // rst_n gating keeps req_ready low while reset is held
    assign req_ready = grant & {2{~stall & ~cfg_hold & rst_n}};
    assign sel       = grant[1];
    assign accept    = |req_ready;

    // ---------------- S2 combinational correction ----------------
    always_comb begin
        tcmp_next = {($signed(s1_tdout_reg) >= $signed(q_reg)), ~s1_tdout_reg[4]};
        case (tcmp_next)
            2'b00:   corr_next = s1_tdout_reg + q_reg;
            2'b11:   corr_next = s1_tdout_reg - q_reg;
            default: corr_next = s1_tdout_reg;
        endcase
    end

    // ---------------- Pipeline registers ----------------
    // A stall freezes every stage so response fields stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_port_reg  <= 1'b0;
            s1_tag_reg   <= '0;
            s1_tdout_reg <= '0;
            s2_valid_reg <= 1'b0;
            s2_port_reg  <= 1'b0;
            s2_tag_reg   <= '0;
            s2_tdout_reg <= '0;
            s2_tcmp_reg  <= '0;
            s2_dout_reg  <= '0;
            rsp_valid    <= 1'b0;
            rsp_port     <= 1'b0;
            rsp_tag      <= '0;
            rsp_tdout    <= '0;
            rsp_tcmp     <= '0;
            rsp_dout     <= '0;
        end else if (!stall) begin
            s1_valid_reg <= accept;
            s1_port_reg  <= sel;
            s1_tag_reg   <= tag_arr[sel];
            s1_tdout_reg <= raw_arr[sel];
            s2_valid_reg <= s1_valid_reg;
            s2_port_reg  <= s1_port_reg;
            s2_tag_reg   <= s1_tag_reg;
            s2_tdout_reg <= s1_tdout_reg;
            s2_tcmp_reg  <= tcmp_next;
            s2_dout_reg  <= corr_next[3:0];
            rsp_valid    <= s2_valid_reg;
            rsp_port     <= s2_port_reg;
            rsp_tag      <= s2_tag_reg;
            rsp_tdout    <= s2_tdout_reg;
            rsp_tcmp     <= s2_tcmp_reg;
            rsp_dout     <= s2_dout_reg;
        end
    end

    // ---------------- Q reload controller ----------------
    assign q_ok = ($signed(cfg_q) >= 5'sd1) && ($signed(cfg_q) <= 5'sd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            q_reg     <= Q_RESET;
        end else begin
            state_reg <= state_next;
            if (q_load) q_reg <= cfg_q;
        end
    end

    always_comb begin
        state_next = state_reg;
        cfg_hold   = 1'b0;
        cfg_q_ack  = 1'b0;
        cfg_q_err  = 1'b0;
        q_load     = 1'b0;
        case (state_reg)
            IDLE: begin
                // Hold off grants in the same cycle the request is seen so
                // nothing new enters behind the drain.
                if (cfg_q_req) begin
                    cfg_hold   = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                cfg_hold = 1'b1;
                if (!s1_valid_reg && !s2_valid_reg && !rsp_valid)
                    state_next = LOAD;
            end
            LOAD: begin
                cfg_hold   = 1'b1;
                cfg_q_ack  = 1'b1;
                cfg_q_err  = ~q_ok;
                q_load     = q_ok;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign q_cur = q_reg;

endmodule
